dmem_arbiter: RTL and testbench

//  Shares the single data-memory port (addr/func3/dataW/MemRW in, dataR out; sync write, comb read)

---
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter in front of the single data-memory port
//
// Purpose: shares one data-memory port (comb read, sync write) between the
// pipeline MEM stage (port 0) and a debug/loader port (port 1). Port 0 has
// fixed priority; a starvation counter lets port 1 win one grant after
// STARVE_LIMIT denied cycles; port 1 may lock the memory for bursts.
// Misaligned accesses are granted and flagged but never reach memory.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pN_req/we/func3/addr/wdata request from port N (held until pN_gnt)
//   p1_lock                   sampled at a port-1 grant: keep ownership
//   pN_gnt, pN_err            comb grant and misalignment flag
//   pN_rvalid, pN_rdata       registered load data, cycle after grant
//   mem_addr/func3/dataW/MemRW, mem_dataR   data-memory port
//   busy_p1                   high while port 1 holds the lock
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int AW           = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [2:0]    p0_func3,
    input  logic [AW-1:0] p0_addr,
    input  logic [31:0]   p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [31:0]   p0_rdata,
    output logic          p0_err,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [2:0]    p1_func3,
    input  logic [AW-1:0] p1_addr,
    input  logic [31:0]   p1_wdata,
    input  logic          p1_lock,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [31:0]   p1_rdata,
    output logic          p1_err,
    output logic [AW-1:0] mem_addr,
    output logic [2:0]    mem_func3,
    output logic [31:0]   mem_dataW,
    output logic          mem_MemRW,
    input  logic [31:0]   mem_dataR,
    output logic          busy_p1
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic {ARB, LOCK1} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] starve_cnt, starve_nxt;
    logic          win0, win1;
    logic          mis0, mis1;
    logic          ld0, ld1;
    logic          rv0_q, rv1_q;
    logic [31:0]   rd0_q, rd1_q;

    // Width is func3[1:0]; func3 011/110/111 are never legal.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic m;
        case (f3[1:0])
            2'b00:   m = 1'b0;
            2'b01:   m = a[0];
            2'b10:   m = f3[2] || (a != 2'b00);
            default: m = 1'b1;
        endcase
        return m;
    endfunction

    assign mis0 = misaligned(p0_func3, p0_addr[1:0]);
    assign mis1 = misaligned(p1_func3, p1_addr[1:0]);

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        win0       = 1'b0;
        win1       = 1'b0;
        mem_addr   = '0;
        mem_func3  = 3'b010;
        mem_dataW  = '0;
        mem_MemRW  = 1'b0;

        // Nothing is granted on a reset cycle, so nothing is written either.
        if (!rst) begin
            if (state == LOCK1)
                win1 = p1_req;
            else if (p1_req && (!p0_req || starve_cnt == LIMIT))
                win1 = 1'b1;
            else
                win0 = p0_req;
        end

        if (win1) begin
            starve_nxt = '0;
            state_nxt  = p1_lock ? LOCK1 : ARB;
            mem_addr   = p1_addr;
            mem_func3  = p1_func3;
            mem_dataW  = p1_wdata;
            mem_MemRW  = p1_we && !mis1;
        end else if (win0) begin
            if (p1_req && starve_cnt != LIMIT)
                starve_nxt = starve_cnt + 1'b1;
            mem_addr  = p0_addr;
            mem_func3 = p0_func3;
            mem_dataW = p0_wdata;
            mem_MemRW = p0_we && !mis0;
        end
    end

    assign ld0 = win0 && !p0_we && !mis0;
    assign ld1 = win1 && !p1_we && !mis1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            starve_cnt <= '0;
            rv0_q      <= 1'b0;
            rv1_q      <= 1'b0;
            rd0_q      <= '0;
            rd1_q      <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            rv0_q      <= ld0;
            rv1_q      <= ld1;
            if (ld0)
                rd0_q <= mem_dataR;
            if (ld1)
                rd1_q <= mem_dataR;
        end
    end

    assign p0_gnt = win0;
    assign p1_gnt = win1;
    assign p0_err = win0 && mis0;
    assign p1_err = win1 && mis1;

    // Registered outputs are also masked by rst so a load granted just before
    // reset never shows its data and a lock reads as released at once.
    assign p0_rvalid = rv0_q && !rst;
    assign p1_rvalid = rv1_q && !rst;
    assign p0_rdata  = rst ? 32'd0 : rd0_q;
    assign p1_rdata  = rst ? 32'd0 : rd1_q;
    assign busy_p1   = (state == LOCK1) && !rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0, p1_lock = 0;
    logic [2:0]  p0_func3 = 3'd2, p1_func3 = 3'd2;
    logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_dataW, mem_dataR;
    logic [2:0]  mem_func3;
    logic        mem_MemRW, busy_p1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(8), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_func3(p0_func3), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_func3(p1_func3), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_lock(p1_lock), .p1_gnt(p1_gnt),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_func3(mem_func3), .mem_dataW(mem_dataW),
        .mem_MemRW(mem_MemRW), .mem_dataR(mem_dataR), .busy_p1(busy_p1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    function automatic logic [31:0] ld(input logic [7:0] b0, b1, b2, b3, input logic [2:0] f3);
        case (f3)
            3'd0:    return {{24{b0[7]}}, b0};
            3'd1:    return {{16{b1[7]}}, b1, b0};
            3'd4:    return {24'd0, b0};
            3'd5:    return {16'd0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    // Memory device: comb read with load extension, sync write of low bytes.
    logic [7:0] dev [512];
    logic       dev_ready = 1'b0;
    assign mem_dataR = ld(dev[mem_addr[8:0]], dev[mem_addr[8:0] + 9'd1],
                          dev[mem_addr[8:0] + 9'd2], dev[mem_addr[8:0] + 9'd3], mem_func3);

    always @(posedge clk) begin
        if (!dev_ready) begin
            for (int i = 0; i < 512; i++) dev[i] <= 8'(i * 7 + 3);
            dev_ready <= 1'b1;
        end else if (mem_MemRW) begin
            dev[mem_addr[8:0]] <= mem_dataW[7:0];
            if (mem_func3[1:0] != 2'b00) dev[mem_addr[8:0] + 9'd1] <= mem_dataW[15:8];
            if (mem_func3[1:0] == 2'b10) begin
                dev[mem_addr[8:0] + 9'd2] <= mem_dataW[23:16];
                dev[mem_addr[8:0] + 9'd3] <= mem_dataW[31:24];
            end
        end
    end

    // Reference model: shadow memory plus ownership, starvation count and
    // pending load results, advanced once per cycle from the rules.
    logic [7:0]  sh [512];
    logic        sh_ready = 1'b0;
    logic        cmp_on = 1'b0;
    logic        m_lock = 1'b0;
    int          m_starve = 0;
    logic        m_rv0 = 0, m_rv1 = 0;
    logic [31:0] m_rd0 = 0, m_rd1 = 0;
    logic        g0_seen = 0, g1_seen = 0;
    int          w, sz, ix;
    logic        e_we, e_mis;
    logic [2:0]  e_f3;
    logic [31:0] e_a, e_d;

    always @(negedge clk) begin
        if (!sh_ready) begin
            for (int i = 0; i < 512; i++) sh[i] = 8'(i * 7 + 3);
            sh_ready = 1'b1;
        end
        if (cmp_on) begin
            if (rst) w = -1;
            else if (m_lock) w = p1_req ? 1 : -1;
            else if (p1_req && (!p0_req || m_starve >= 8)) w = 1;
            else if (p0_req) w = 0;
            else w = -1;

            if (w == 0) begin
                e_a = p0_addr; e_f3 = p0_func3; e_d = p0_wdata; e_we = p0_we;
            end else if (w == 1) begin
                e_a = p1_addr; e_f3 = p1_func3; e_d = p1_wdata; e_we = p1_we;
            end else begin
                e_a = 0; e_f3 = 3'd2; e_d = 0; e_we = 0;
            end
            sz = (e_f3 == 3'd0 || e_f3 == 3'd4) ? 1 :
                 (e_f3 == 3'd1 || e_f3 == 3'd5) ? 2 : (e_f3 == 3'd2) ? 4 : 0;
            e_mis = (w >= 0) && (sz == 0 || (e_a % sz) != 0);

            chk1("p0_gnt", p0_gnt, w == 0);
            chk1("p1_gnt", p1_gnt, w == 1);
            chk1("p0_err", p0_err, w == 0 && e_mis);
            chk1("p1_err", p1_err, w == 1 && e_mis);
            chk("mem_addr", mem_addr, e_a);
            chk("mem_func3", {29'd0, mem_func3}, {29'd0, e_f3});
            chk("mem_dataW", mem_dataW, e_d);
            chk1("mem_MemRW", mem_MemRW, w >= 0 && e_we && !e_mis);
            chk1("p0_rvalid", p0_rvalid, m_rv0 && !rst);
            chk1("p1_rvalid", p1_rvalid, m_rv1 && !rst);
            chk1("busy_p1", busy_p1, m_lock && !rst);
            if (m_rv0 && !rst) chk("p0_rdata", p0_rdata, m_rd0);
            if (m_rv1 && !rst) chk("p1_rdata", p1_rdata, m_rd1);

            g0_seen = p0_gnt;
            g1_seen = p1_gnt;

            if (rst) begin
                m_lock = 0; m_starve = 0; m_rv0 = 0; m_rv1 = 0;
            end else begin
                ix = int'(e_a % 512);
                m_rv0 = (w == 0) && !e_we && !e_mis;
                m_rv1 = (w == 1) && !e_we && !e_mis;
                if (m_rv0 || m_rv1) begin
                    if (m_rv0) m_rd0 = ld(sh[ix], sh[(ix+1)%512], sh[(ix+2)%512], sh[(ix+3)%512], e_f3);
                    else       m_rd1 = ld(sh[ix], sh[(ix+1)%512], sh[(ix+2)%512], sh[(ix+3)%512], e_f3);
                end
                if (w >= 0 && e_we && !e_mis)
                    for (int k = 0; k < sz; k++) sh[(ix + k) % 512] = e_d[8*k +: 8];
                if (w == 1) begin
                    m_starve = 0;
                    m_lock = p1_lock;
                end else if (w == 0 && p1_req && m_starve < 8) begin
                    m_starve++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic req, we, input logic [2:0] f3, input logic [31:0] a, d);
        p0_req = req; p0_we = we; p0_func3 = f3; p0_addr = a; p0_wdata = d;
    endtask

    task automatic set_p1(input logic req, we, input logic [2:0] f3, input logic [31:0] a, d, input logic lk);
        p1_req = req; p1_we = we; p1_func3 = f3; p1_addr = a; p1_wdata = d; p1_lock = lk;
    endtask

    logic [2:0] f3_tab [11] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    int denied;

    initial begin
        // 1: reset with both requests asserted
        set_p0(1, 1, 3'd2, 32'h100, 32'h1234_5678);
        set_p1(1, 1, 3'd2, 32'h104, 32'h8765_4321, 1);
        step();
        cmp_on = 1'b1;
        step();
        #3;
        chk1("rst_p0_gnt", p0_gnt, 1'b0);
        chk1("rst_p1_gnt", p1_gnt, 1'b0);
        chk1("rst_memrw", mem_MemRW, 1'b0);
        chk1("rst_busy", busy_p1, 1'b0);
        chk1("rst_p0_rvalid", p0_rvalid, 1'b0);

        // 2: both request, p0 store wins, p1 load follows and sees the data
        step();
        rst = 0;
        set_p0(1, 1, 3'd2, 32'h100, 32'hDEAD_BEEF);
        set_p1(1, 0, 3'd2, 32'h100, 32'h0, 0);
        #3;
        chk1("t2_p0_gnt", p0_gnt, 1'b1);
        chk1("t2_p1_wait", p1_gnt, 1'b0);
        step();
        p0_req = 0;
        #3;
        chk1("t2_p1_gnt", p1_gnt, 1'b1);
        step();
        p1_req = 0;
        #3;
        chk1("t2_p1_rvalid", p1_rvalid, 1'b1);
        chk("t2_p1_rdata", p1_rdata, 32'hDEAD_BEEF);

        // 3: starvation guard
        step();
        set_p0(1, 0, 3'd2, 32'h104, 32'h0);
        set_p1(1, 0, 3'd2, 32'h100, 32'h0, 0);
        denied = 0;
        for (int k = 0; k < 20; k++) begin
            #3;
            if (p1_gnt) break;
            chk1("t3_p0_gnt", p0_gnt, 1'b1);
            denied++;
            step();
        end
        chk("t3_denied", denied, 8);
        chk1("t3_p1_gnt", p1_gnt, 1'b1);
        step();
        p1_req = 0;
        #3;
        chk1("t3_p0_resume", p0_gnt, 1'b1);

        // 4: locked byte burst from port 1
        step();
        p0_req = 0;
        set_p1(1, 1, 3'd0, 32'h20, 32'h11, 1);
        #3;
        chk1("t4_p1_gnt0", p1_gnt, 1'b1);
        chk1("t4_p0_gnt0", p0_gnt, 1'b0);
        for (int i = 1; i < 4; i++) begin
            step();
            set_p0(1, 0, 3'd2, 32'h104, 32'h0);
            set_p1(1, 1, 3'd0, 32'h20 + i, 32'(8'h11 * (i + 1)), i < 3);
            #3;
            chk1("t4_p0_gnt", p0_gnt, 1'b0);
            chk1("t4_p1_gnt", p1_gnt, 1'b1);
            chk1("t4_busy", busy_p1, 1'b1);
        end
        step();
        p1_req = 0;
        #3;
        chk1("t4_unlock_busy", busy_p1, 1'b0);
        chk1("t4_p0_gnt_after", p0_gnt, 1'b1);
        step();
        p0_req = 0;
        set_p1(1, 0, 3'd2, 32'h20, 32'h0, 0);
        step();
        p1_req = 0;
        #3;
        chk1("t4_rvalid", p1_rvalid, 1'b1);
        chk("t4_rdata", p1_rdata, 32'h4433_2211);

        // 5: misaligned accesses are flagged and suppressed
        step();
        set_p0(1, 0, 3'd2, 32'h102, 32'h0);
        #3;
        chk1("t5_gnt", p0_gnt, 1'b1);
        chk1("t5_err", p0_err, 1'b1);
        chk1("t5_memrw", mem_MemRW, 1'b0);
        step();
        set_p0(1, 1, 3'd1, 32'h101, 32'h0000_AAAA);
        #3;
        chk1("t5_no_rvalid", p0_rvalid, 1'b0);
        chk1("t5_sh_err", p0_err, 1'b1);
        chk1("t5_sh_memrw", mem_MemRW, 1'b0);
        step();
        p0_req = 0;
        set_p1(1, 0, 3'd2, 32'h100, 32'h0, 0);
        step();
        p1_req = 0;
        #3;
        chk("t5_mem_unchanged", p1_rdata, 32'hDEAD_BEEF);

        // 6: reset drops a pending load and aborts a lock
        step();
        set_p0(1, 0, 3'd2, 32'h100, 32'h0);
        #3;
        chk1("t6_gnt", p0_gnt, 1'b1);
        step();
        p0_req = 0;
        rst = 1;
        #3;
        chk1("t6_rvalid_rst", p0_rvalid, 1'b0);
        step();
        rst = 0;
        #3;
        chk1("t6_rvalid_after", p0_rvalid, 1'b0);
        step();
        set_p1(1, 1, 3'd2, 32'h40, 32'h1, 1);
        #3;
        chk1("t6_lock_gnt", p1_gnt, 1'b1);
        step();
        p1_req = 0;
        #3;
        chk1("t6_busy", busy_p1, 1'b1);
        step();
        rst = 1;
        #3;
        chk1("t6_busy_rst", busy_p1, 1'b0);
        step();
        rst = 0;
        set_p0(1, 0, 3'd2, 32'h104, 32'h0);
        #3;
        chk1("t6_arb_p0", p0_gnt, 1'b1);
        step();
        p0_req = 0;

        // Randomized traffic; requests are held until granted.
        for (int c = 0; c < 4000; c++) begin
            step();
            rst = ($urandom_range(0, 99) == 0);
            if (!p0_req || g0_seen)
                set_p0($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                       f3_tab[$urandom_range(0, 10)], 32'($urandom_range(0, 511)), $urandom);
            if (!p1_req || g1_seen)
                set_p1($urandom_range(0, 9) < 5, 1'($urandom_range(0, 1)),
                       f3_tab[$urandom_range(0, 10)], 32'($urandom_range(0, 511)), $urandom,
                       $urandom_range(0, 3) == 0);
        end
        step();
        p0_req = 0;
        p1_req = 0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
